// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART blocks.
package uart_pkg;

    // Smallest divisor accepted from cfg_div; anything below falls back to the default.
    localparam int unsigned MIN_DIV = 2;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    // Map the raw 2-bit parity field onto the parity mode; code 3 behaves as none.
    function automatic parity_e decode_parity(input logic [1:0] mode);
        parity_e p;
        case (mode)
            2'd1:    p = PAR_EVEN;
            2'd2:    p = PAR_ODD;
            default: p = PAR_NONE;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Baud divisor counter: counts 0..div-1 and flags the last cycle of each bit period.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 restart,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 tick_c
);

    logic [DIV_WIDTH-1:0] cnt_q;
    logic [DIV_WIDTH-1:0] cnt_d;

    // Tick on the final count of the bit period.
    always_comb begin
        tick_c = (cnt_q == (div - DIV_WIDTH'(1)));
    end

    // Next count: wrap after the tick, or jump back to zero when a frame is loaded.
    always_comb begin
        cnt_d = cnt_q + DIV_WIDTH'(1);
        if (restart || tick_c) begin
            cnt_d = '0;
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter with a one-entry holding buffer.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned DIV_WIDTH   = 16,
    parameter int unsigned DEFAULT_DIV = 5208
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [DIV_WIDTH-1:0]  cfg_div,
    input  logic [1:0]            cfg_parity,
    input  logic                  cfg_stop2,
    output logic                  tx_busy,
    output logic                  tx_wire
);

    localparam int unsigned BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    tx_state_e             state_q,    state_d;
    logic [DATA_WIDTH-1:0] buf_data_q, buf_data_d;
    logic                  buf_full_q, buf_full_d;
    logic                  tready_q,   tready_d;
    logic [DATA_WIDTH-1:0] shift_q,    shift_d;
    logic [BIT_W-1:0]      bit_idx_q,  bit_idx_d;
    logic                  stop_cnt_q, stop_cnt_d;
    logic [DIV_WIDTH-1:0]  div_q,      div_d;
    logic                  par_en_q,   par_en_d;
    logic                  par_bit_q,  par_bit_d;
    logic                  stop2_q,    stop2_d;
    logic                  busy_q,     busy_d;
    logic                  tx_wire_q,  tx_wire_d;

    logic                  tick_c;
    logic                  last_stop_c;
    logic                  load_c;
    logic [DIV_WIDTH-1:0]  eff_div_c;
    parity_e               par_mode_c;

    // Bit-period timing; restarted on every frame load so the start bit is full length.
    uart_baud_gen #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .restart (load_c),
        .div     (div_q),
        .tick_c  (tick_c)
    );

    // Frame configuration as it will be latched at the next load.
    always_comb begin
        eff_div_c  = (cfg_div >= DIV_WIDTH'(MIN_DIV)) ? cfg_div : DIV_WIDTH'(DEFAULT_DIV);
        par_mode_c = decode_parity(cfg_parity);
    end

    // A frame loads from IDLE, or straight out of the final stop period when the buffer is full.
    always_comb begin
        last_stop_c = (state_q == STOP) && tick_c && !(stop2_q && !stop_cnt_q);
        load_c      = buf_full_q && ((state_q == IDLE) || last_stop_c);
    end

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_d    = state_q;
        buf_data_d = buf_data_q;
        buf_full_d = buf_full_q;
        tready_d   = tready_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        stop_cnt_d = stop_cnt_q;
        div_d      = div_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        stop2_d    = stop2_q;
        busy_d     = busy_q;
        tx_wire_d  = tx_wire_q;

        // Holding buffer accept; tready is low whenever the buffer is full, so this never meets a load.
        if (s_axis_tvalid && tready_q) begin
            buf_data_d = s_axis_tdata;
            buf_full_d = 1'b1;
            tready_d   = 1'b0;
        end

        case (state_q)
            IDLE: begin
                tx_wire_d = 1'b1;
            end
            START: begin
                if (tick_c) begin
                    state_d   = DATA;
                    tx_wire_d = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (tick_c) begin
                    if (bit_idx_q == BIT_W'(DATA_WIDTH - 1)) begin
                        if (par_en_q) begin
                            state_d   = PARITY;
                            tx_wire_d = par_bit_q;
                        end else begin
                            state_d    = STOP;
                            tx_wire_d  = 1'b1;
                            stop_cnt_d = 1'b0;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + BIT_W'(1);
                        tx_wire_d = shift_q[0];
                        shift_d   = shift_q >> 1;
                    end
                end
            end
            PARITY: begin
                if (tick_c) begin
                    state_d    = STOP;
                    tx_wire_d  = 1'b1;
                    stop_cnt_d = 1'b0;
                end
            end
            STOP: begin
                if (tick_c) begin
                    if (stop2_q && !stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                    end else if (!buf_full_q) begin
                        state_d   = IDLE;
                        busy_d    = 1'b0;
                        tx_wire_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                busy_d    = 1'b0;
                tx_wire_d = 1'b1;
            end
        endcase

        // Frame load: move the buffer into the shifter, latch config, drive the start bit.
        if (load_c) begin
            state_d    = START;
            shift_d    = buf_data_q;
            buf_full_d = 1'b0;
            tready_d   = 1'b1;
            div_d      = eff_div_c;
            par_en_d   = (par_mode_c != PAR_NONE);
            par_bit_d  = (^buf_data_q) ^ (par_mode_c == PAR_ODD);
            stop2_d    = cfg_stop2;
            bit_idx_d  = '0;
            stop_cnt_d = 1'b0;
            busy_d     = 1'b1;
            tx_wire_d  = 1'b0;
        end
    end

    // All state and outputs registered; synchronous active-low reset aborts any frame.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            buf_data_q <= '0;
            buf_full_q <= 1'b0;
            tready_q   <= 1'b1;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            stop_cnt_q <= 1'b0;
            div_q      <= DIV_WIDTH'(DEFAULT_DIV);
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            stop2_q    <= 1'b0;
            busy_q     <= 1'b0;
            tx_wire_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            buf_data_q <= buf_data_d;
            buf_full_q <= buf_full_d;
            tready_q   <= tready_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            stop_cnt_q <= stop_cnt_d;
            div_q      <= div_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            stop2_q    <= stop2_d;
            busy_q     <= busy_d;
            tx_wire_q  <= tx_wire_d;
        end
    end

    always_comb begin
        s_axis_tready = tready_q;
        tx_busy       = busy_q;
        tx_wire       = tx_wire_q;
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: frame waveforms, parity, stop bits, back-to-back, config latching, reset.
module tb_uart_tx_cfg;

    localparam int unsigned DW  = 8;
    localparam int unsigned VW  = 16;
    localparam int unsigned DEF = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [VW-1:0] cfg_div;
    logic [1:0]    cfg_parity;
    logic          cfg_stop2;
    logic          tx_busy;
    logic          tx_wire;

    int total = 0;
    int bad   = 0;

    uart_tx_cfg #(
        .DATA_WIDTH  (DW),
        .DIV_WIDTH   (VW),
        .DEFAULT_DIV (DEF)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .cfg_div       (cfg_div),
        .cfg_parity    (cfg_parity),
        .cfg_stop2     (cfg_stop2),
        .tx_busy       (tx_busy),
        .tx_wire       (tx_wire)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, required finish before 400000ns");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one byte and wait for the handshake edge; returns 1ns after it.
    task automatic send(input logic [7:0] d);
        bit hs;
        hs = 1'b0;
        s_axis_tdata  = d;
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 300 && !hs; i++) begin
            hs = s_axis_tready;
            step();
        end
        s_axis_tvalid = 1'b0;
        total++;
        if (hs !== 1'b1) begin
            bad++;
            $display("FAIL send_handshake data=%h got handshake=%0b required 1", d, hs);
        end
    endtask

    // Record n consecutive cycles of tx_wire / tx_busy starting at the current sample.
    task automatic capture(input int n, output logic [255:0] w, output logic [255:0] b);
        w = '0;
        b = '0;
        for (int k = 0; k < n; k++) begin
            w[k] = tx_wire;
            b[k] = tx_busy;
            if (k < n - 1) step();
        end
    endtask

    // Append the expected line waveform of one frame.
    task automatic add_wave(input logic [7:0] d, input int div, input int par, input bit stop2,
                            inout logic [255:0] w, inout int idx);
        logic [11:0] bits;
        int nb;
        nb = 0;
        bits = '0;
        bits[nb] = 1'b0; nb++;
        for (int i = 0; i < 8; i++) begin bits[nb] = d[i]; nb++; end
        if (par == 1) begin bits[nb] = ^d; nb++; end
        if (par == 2) begin bits[nb] = ~(^d); nb++; end
        bits[nb] = 1'b1; nb++;
        if (stop2) begin bits[nb] = 1'b1; nb++; end
        for (int i = 0; i < nb; i++)
            for (int j = 0; j < div; j++) begin w[idx] = bits[i]; idx++; end
    endtask

    function automatic logic [255:0] ones(input int n);
        logic [255:0] m;
        m = '0;
        for (int i = 0; i < n; i++) m[i] = 1'b1;
        return m;
    endfunction

    task automatic test_reset();
        int viol;
        rst = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        cfg_div = 16'd4; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
        repeat (3) step();
        total++;
        if ({tx_wire, s_axis_tready, tx_busy} !== 3'b110) begin
            bad++;
            $display("FAIL reset_state got wire/tready/busy=%b required 110", {tx_wire, s_axis_tready, tx_busy});
        end
        rst = 1'b1;
        viol = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if ({tx_wire, s_axis_tready, tx_busy} !== 3'b110) viol++;
        end
        total++;
        if (viol !== 0) begin
            bad++;
            $display("FAIL idle_100 got %0d non-idle cycles required 0", viol);
        end
    endtask

    task automatic test_8n1();
        logic [255:0] w, b, e;
        logic [9:0]   got_bits, hand;
        int idx;
        cfg_div = 16'd4; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
        send(8'hA5);
        total++;
        if (tx_wire !== 1'b1) begin
            bad++;
            $display("FAIL 8n1_pre_start got wire=%b required 1", tx_wire);
        end
        step();
        capture(40, w, b);
        e = '0; idx = 0;
        add_wave(8'hA5, 4, 0, 1'b0, e, idx);
        total++;
        if (w !== e) begin bad++; $display("FAIL 8n1_wave got=%h required=%h", w, e); end
        hand = 10'b1101001010;
        for (int k = 0; k < 10; k++) got_bits[k] = w[k*4 + 2];
        total++;
        if (got_bits !== hand) begin bad++; $display("FAIL 8n1_bits got=%b required=%b", got_bits, hand); end
        total++;
        if (b !== ones(40)) begin bad++; $display("FAIL 8n1_busy got=%h required=%h", b, ones(40)); end
        step();
        total++;
        if ({tx_wire, s_axis_tready, tx_busy} !== 3'b110) begin
            bad++;
            $display("FAIL 8n1_end got wire/tready/busy=%b required 110", {tx_wire, s_axis_tready, tx_busy});
        end
    endtask

    task automatic test_parity_stop2();
        logic [255:0] w, b, e;
        int idx;
        for (int m = 1; m <= 2; m++) begin
            cfg_div = 16'd4; cfg_parity = 2'(m); cfg_stop2 = 1'b1;
            send(8'hA5);
            step();
            capture(48, w, b);
            e = '0; idx = 0;
            add_wave(8'hA5, 4, m, 1'b1, e, idx);
            total++;
            if (w !== e) begin bad++; $display("FAIL par%0d_wave got=%h required=%h", m, w, e); end
            total++;
            if (w[38] !== ((m == 2) ? 1'b1 : 1'b0)) begin
                bad++;
                $display("FAIL par%0d_bit got=%b required=%b", m, w[38], (m == 2) ? 1'b1 : 1'b0);
            end
            total++;
            if (b !== ones(48)) begin bad++; $display("FAIL par%0d_busy got=%h required=%h", m, b, ones(48)); end
            step();
            total++;
            if (tx_busy !== 1'b0) begin bad++; $display("FAIL par%0d_len got busy=%b at cycle 48 required 0", m, tx_busy); end
        end
        cfg_parity = 2'd0; cfg_stop2 = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [255:0] w, b, e;
        int idx;
        cfg_div = 16'd4; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
        send(8'h00);
        fork
            begin
                send(8'hFF);
                total++;
                if (tx_busy !== 1'b1) begin bad++; $display("FAIL b2b_second_hs got busy=%b required 1", tx_busy); end
            end
            begin
                step();
                capture(80, w, b);
            end
        join
        e = '0; idx = 0;
        add_wave(8'h00, 4, 0, 1'b0, e, idx);
        add_wave(8'hFF, 4, 0, 1'b0, e, idx);
        total++;
        if (w !== e) begin bad++; $display("FAIL b2b_wave got=%h required=%h", w, e); end
        total++;
        if (b !== ones(80)) begin bad++; $display("FAIL b2b_busy got=%h required=%h", b, ones(80)); end
        step();
        total++;
        if (tx_busy !== 1'b0) begin bad++; $display("FAIL b2b_end got busy=%b required 0", tx_busy); end
    endtask

    task automatic test_div_clamp();
        logic [255:0] w, b, e;
        int idx;
        cfg_div = 16'd1;
        send(8'h96);
        step();
        capture(120, w, b);
        e = '0; idx = 0;
        add_wave(8'h96, DEF, 0, 1'b0, e, idx);
        total++;
        if (w !== e) begin bad++; $display("FAIL clamp_wave got=%h required=%h", w, e); end
        total++;
        if (b !== ones(120)) begin bad++; $display("FAIL clamp_busy got=%h required=%h", b, ones(120)); end
        step();
        cfg_div = 16'd2;
        send(8'h96);
        step();
        capture(20, w, b);
        e = '0; idx = 0;
        add_wave(8'h96, 2, 0, 1'b0, e, idx);
        total++;
        if (w !== e) begin bad++; $display("FAIL div2_wave got=%h required=%h", w, e); end
        step();
        total++;
        if (tx_busy !== 1'b0) begin bad++; $display("FAIL div2_end got busy=%b required 0", tx_busy); end
    endtask

    task automatic test_cfg_latch();
        logic [255:0] w, b, e;
        int idx;
        cfg_div = 16'd4;
        send(8'h0F);
        fork
            begin
                step();
                capture(120, w, b);
            end
            begin
                repeat (10) step();
                cfg_div = 16'd8;
                send(8'h81);
            end
        join
        e = '0; idx = 0;
        add_wave(8'h0F, 4, 0, 1'b0, e, idx);
        add_wave(8'h81, 8, 0, 1'b0, e, idx);
        total++;
        if (w !== e) begin bad++; $display("FAIL latch_wave got=%h required=%h", w, e); end
        total++;
        if (b !== ones(120)) begin bad++; $display("FAIL latch_busy got=%h required=%h", b, ones(120)); end
        step();
        total++;
        if (tx_busy !== 1'b0) begin bad++; $display("FAIL latch_end got busy=%b required 0", tx_busy); end
        cfg_div = 16'd4;
    endtask

    task automatic test_reset_mid();
        logic [255:0] w, b, e;
        int idx, viol;
        cfg_div = 16'd4; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
        send(8'h3C);
        repeat (17) step();
        total++;
        if ({tx_wire, tx_busy} !== 2'b11) begin
            bad++;
            $display("FAIL mid_bit3 got wire/busy=%b required 11", {tx_wire, tx_busy});
        end
        rst = 1'b0;
        step();
        rst = 1'b1;
        total++;
        if ({tx_wire, s_axis_tready, tx_busy} !== 3'b110) begin
            bad++;
            $display("FAIL mid_reset got wire/tready/busy=%b required 110", {tx_wire, s_axis_tready, tx_busy});
        end
        viol = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if ({tx_wire, tx_busy} !== 2'b10) viol++;
        end
        total++;
        if (viol !== 0) begin bad++; $display("FAIL mid_discard got %0d active cycles required 0", viol); end
        send(8'h3C);
        step();
        capture(40, w, b);
        e = '0; idx = 0;
        add_wave(8'h3C, 4, 0, 1'b0, e, idx);
        total++;
        if (w !== e) begin bad++; $display("FAIL mid_resend_wave got=%h required=%h", w, e); end
        step();
        total++;
        if (tx_busy !== 1'b0) begin bad++; $display("FAIL mid_resend_end got busy=%b required 0", tx_busy); end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity_stop2();
        test_back_to_back();
        test_div_clamp();
        test_cfg_latch();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
